// File: rtl/multi_ball.sv
// multi_ball: NUM_BALLS bouncing square sprites composited into one video bit.
// Positions advance in a one-ball-per-clock sweep started from vertical blanking.
module multi_ball #(
  parameter int NUM_BALLS  = 2,
  parameter int BALL_SIZE  = 8,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int SPEED      = 2,
  parameter int MOVE_DIV   = 1,
  parameter int NET_BOUNCE = 0,
  parameter int NET_X      = 316,
  parameter int NET_W      = 8
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic [9:0] i_HSync_Pos,
  input  logic [9:0] i_VSync_Pos,
  input  logic       i_Pause,
  output logic       o_Video,
  output logic [2:0] o_Ball_Id,
  output logic       o_Bounce,
  output logic       o_Frame_Done
);

  typedef enum logic {S_IDLE, S_UPDATE} state_t;

  localparam logic signed [11:0] SPD  = 12'(SPEED);
  localparam logic signed [11:0] BSZ  = 12'(BALL_SIZE);
  localparam logic signed [11:0] XLIM = 12'(H_ACTIVE - BALL_SIZE);
  localparam logic signed [11:0] YLIM = 12'(V_ACTIVE - BALL_SIZE);
  localparam logic signed [11:0] NETL = 12'(NET_X);
  localparam logic signed [11:0] NETR = 12'(NET_X + NET_W);
  localparam logic [2:0]         LAST = 3'(NUM_BALLS - 1);
  localparam logic [3:0]         DIV  = 4'(MOVE_DIV);

  state_t     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] div_q, div_d;
  logic [9:0] x_q [NUM_BALLS];
  logic [9:0] x_d [NUM_BALLS];
  logic [9:0] y_q [NUM_BALLS];
  logic [9:0] y_d [NUM_BALLS];
  logic       dxn_q [NUM_BALLS];
  logic       dxn_d [NUM_BALLS];
  logic       dyn_q [NUM_BALLS];
  logic       dyn_d [NUM_BALLS];
  logic       video_q, video_d;
  logic [2:0] id_q, id_d;
  logic       bounce_q, bounce_d;
  logic       done_q, done_d;

  logic              tick, step, last;
  logic [3:0]        div_inc;
  logic [9:0]        cur_x, cur_y, nx, ny;
  logic              cur_dxn, cur_dyn, ndxn, ndyn, rev, net_hit;
  logic signed [11:0] cx, cy;

  assign tick = (state_q == S_IDLE) && !i_Pause &&
                (i_HSync_Pos == 10'd0) &&
                (i_VSync_Pos == 10'(V_ACTIVE));
  assign div_inc = div_q + 4'd1;
  assign step = tick && (div_inc == DIV);
  assign last = (idx_q == LAST);

  always_comb begin
    div_d = div_q;
    if (tick) div_d = step ? 4'd0 : div_inc;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      S_IDLE: if (step) begin
        state_d = S_UPDATE;
        idx_d   = 3'd0;
      end
      S_UPDATE: if (last) state_d = S_IDLE;
                else idx_d = idx_q + 3'd1;
    endcase
  end

  always_comb begin
    cur_x = '0; cur_y = '0; cur_dxn = 1'b0; cur_dyn = 1'b0;
    for (int k = 0; k < NUM_BALLS; k++) begin
      if (idx_q == 3'(k)) begin
        cur_x = x_q[k]; cur_y = y_q[k];
        cur_dxn = dxn_q[k]; cur_dyn = dyn_q[k];
      end
    end
  end

  // Net overlap wins over the walls on the x axis.
  always_comb begin
    cx = cur_dxn ? $signed({2'b00, cur_x}) - SPD
                 : $signed({2'b00, cur_x}) + SPD;
    cy = cur_dyn ? $signed({2'b00, cur_y}) - SPD
                 : $signed({2'b00, cur_y}) + SPD;
    net_hit = (NET_BOUNCE != 0) && (cx < NETR) && (cx + BSZ > NETL);
    nx = cx[9:0]; ndxn = cur_dxn;
    if (net_hit) begin
      nx = cur_x; ndxn = !cur_dxn;
    end else if (cx <= 12'sd0) begin
      nx = 10'd0; ndxn = 1'b0;
    end else if (cx >= XLIM) begin
      nx = XLIM[9:0]; ndxn = 1'b1;
    end
    ny = cy[9:0]; ndyn = cur_dyn;
    if (cy <= 12'sd0) begin
      ny = 10'd0; ndyn = 1'b0;
    end else if (cy >= YLIM) begin
      ny = YLIM[9:0]; ndyn = 1'b1;
    end
    rev = (ndxn != cur_dxn) || (ndyn != cur_dyn);
  end

  always_comb begin
    x_d = x_q; y_d = y_q; dxn_d = dxn_q; dyn_d = dyn_q;
    for (int k = 0; k < NUM_BALLS; k++) begin
      if (state_q == S_UPDATE && idx_q == 3'(k)) begin
        x_d[k] = nx; y_d[k] = ny;
        dxn_d[k] = ndxn; dyn_d[k] = ndyn;
      end
    end
  end

  always_comb begin
    bounce_d = (state_q == S_UPDATE) && rev;
    done_d   = (state_q == S_UPDATE) && last;
  end

  // Descending scan leaves the lowest covering index in id_d.
  always_comb begin
    video_d = 1'b0;
    id_d    = 3'd0;
    for (int k = NUM_BALLS - 1; k >= 0; k--) begin
      if ({1'b0, i_HSync_Pos} >= {1'b0, x_q[k]} &&
          {1'b0, i_HSync_Pos} < {1'b0, x_q[k]} + 11'(BALL_SIZE) &&
          {1'b0, i_VSync_Pos} >= {1'b0, y_q[k]} &&
          {1'b0, i_VSync_Pos} < {1'b0, y_q[k]} + 11'(BALL_SIZE)) begin
        video_d = 1'b1;
        id_d    = 3'(k);
      end
    end
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q  <= S_IDLE;
      idx_q    <= 3'd0;
      div_q    <= 4'd0;
      video_q  <= 1'b0;
      id_q     <= 3'd0;
      bounce_q <= 1'b0;
      done_q   <= 1'b0;
      for (int k = 0; k < NUM_BALLS; k++) begin
        x_q[k]   <= 10'(32 + 64 * k);
        y_q[k]   <= 10'(32 + 48 * k);
        dxn_q[k] <= 1'((k % 2));
        dyn_q[k] <= 1'b0;
      end
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      div_q    <= div_d;
      video_q  <= video_d;
      id_q     <= id_d;
      bounce_q <= bounce_d;
      done_q   <= done_d;
      for (int k = 0; k < NUM_BALLS; k++) begin
        x_q[k]   <= x_d[k];
        y_q[k]   <= y_d[k];
        dxn_q[k] <= dxn_d[k];
        dyn_q[k] <= dyn_d[k];
      end
    end
  end

  assign o_Video      = video_q;
  assign o_Ball_Id    = id_q;
  assign o_Bounce     = bounce_q;
  assign o_Frame_Done = done_q;

endmodule

// File: tb/tb_multi_ball.sv
// Bench for multi_ball: three configurations (default, net bounce, divide-by-3)
// share stimulus; a ball-level model predicts positions, pulses and pixels.
module tb_multi_ball;
  localparam int NB = 2;
  localparam int BS = 8;
  localparam int HA = 640;
  localparam int VA = 480;
  localparam int SP = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] h = 10'd700;
  logic [9:0] v = 10'd500;
  logic       pause = 1'b0;
  logic       vid [3];
  logic [2:0] bid [3];
  logic       bnc [3];
  logic       fd  [3];

  always #5 clk = ~clk;

  multi_ball dut0 (
    .i_Clk(clk), .i_Rst(rst), .i_HSync_Pos(h), .i_VSync_Pos(v),
    .i_Pause(pause), .o_Video(vid[0]), .o_Ball_Id(bid[0]),
    .o_Bounce(bnc[0]), .o_Frame_Done(fd[0]));
  multi_ball #(.NET_BOUNCE(1)) dut1 (
    .i_Clk(clk), .i_Rst(rst), .i_HSync_Pos(h), .i_VSync_Pos(v),
    .i_Pause(pause), .o_Video(vid[1]), .o_Ball_Id(bid[1]),
    .o_Bounce(bnc[1]), .o_Frame_Done(fd[1]));
  multi_ball #(.MOVE_DIV(3)) dut2 (
    .i_Clk(clk), .i_Rst(rst), .i_HSync_Pos(h), .i_VSync_Pos(v),
    .i_Pause(pause), .o_Video(vid[2]), .o_Ball_Id(bid[2]),
    .o_Bounce(bnc[2]), .o_Frame_Done(fd[2]));

  int checks = 0;
  int failures = 0;

  int mx [3][NB];
  int my [3][NB];
  bit mdx [3][NB];
  bit mdy [3][NB];
  int mdiv [3];
  bit upd [3];
  bit mb [3][NB];
  bit done_s [3][4];
  bit bnc_s [3][4];

  typedef struct {int hh; int vv; int vid; int id;} vec_t;
  vec_t vecs [8];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic get_pos(input int c, input int b, output int x, output int y);
    x = 0; y = 0;
    case (c)
      0: begin x = int'(dut0.x_q[b]); y = int'(dut0.y_q[b]); end
      1: begin x = int'(dut1.x_q[b]); y = int'(dut1.y_q[b]); end
      default: begin x = int'(dut2.x_q[b]); y = int'(dut2.y_q[b]); end
    endcase
  endtask

  task automatic model_reset();
    for (int c = 0; c < 3; c++) begin
      mdiv[c] = 0;
      for (int b = 0; b < NB; b++) begin
        mx[c][b] = 32 + 64 * b;
        my[c][b] = 32 + 48 * b;
        mdx[c][b] = (b % 2) == 1;
        mdy[c][b] = 1'b0;
      end
    end
  endtask

  task automatic wall(input int pos, input bit neg, input int lim,
                      output int np, output bit nn);
    int cand;
    cand = neg ? pos - SP : pos + SP;
    np = cand; nn = neg;
    if (cand <= 0) begin np = 0; nn = 1'b0; end
    else if (cand >= lim) begin np = lim; nn = 1'b1; end
  endtask

  task automatic model_tick();
    int nx, ny, cand;
    bit ndx, ndy;
    for (int c = 0; c < 3; c++) begin
      upd[c] = 1'b0;
      for (int b = 0; b < NB; b++) mb[c][b] = 1'b0;
      if (!pause) begin
        mdiv[c]++;
        if (mdiv[c] == ((c == 2) ? 3 : 1)) begin
          mdiv[c] = 0;
          upd[c] = 1'b1;
          for (int b = 0; b < NB; b++) begin
            cand = mdx[c][b] ? mx[c][b] - SP : mx[c][b] + SP;
            if (c == 1 && cand < 316 + 8 && cand + BS > 316) begin
              nx = mx[c][b]; ndx = !mdx[c][b];
            end else begin
              wall(mx[c][b], mdx[c][b], HA - BS, nx, ndx);
            end
            wall(my[c][b], mdy[c][b], VA - BS, ny, ndy);
            mb[c][b] = (ndx != mdx[c][b]) || (ndy != mdy[c][b]);
            mx[c][b] = nx; my[c][b] = ny;
            mdx[c][b] = ndx; mdy[c][b] = ndy;
          end
        end
      end
    end
  endtask

  task automatic check_pos(input int c);
    int x, y;
    for (int b = 0; b < NB; b++) begin
      get_pos(c, b, x, y);
      chk($sformatf("x c%0d b%0d", c, b), x, mx[c][b]);
      chk($sformatf("y c%0d b%0d", c, b), y, my[c][b]);
    end
  endtask

  task automatic sample(input int j);
    for (int c = 0; c < 3; c++) begin
      done_s[c][j] = fd[c];
      bnc_s[c][j] = bnc[c];
    end
  endtask

  task automatic do_tick();
    @(negedge clk); h = 10'd0; v = 10'(VA);
    @(posedge clk); #1; h = 10'd700; v = 10'd500;
    sample(0);
    for (int j = 1; j < 4; j++) begin
      @(posedge clk); #1; sample(j);
    end
    model_tick();
    for (int c = 0; c < 3; c++) begin
      for (int j = 0; j < 4; j++) begin
        chk($sformatf("done c%0d j%0d", c, j), int'(done_s[c][j]),
            int'(upd[c] && j == 2));
        chk($sformatf("bounce c%0d j%0d", c, j), int'(bnc_s[c][j]),
            (j == 1) ? int'(mb[c][0]) : (j == 2) ? int'(mb[c][1]) : 0);
      end
      check_pos(c);
    end
  endtask

  task automatic probe(input int hh, input int vv);
    int ev, eid;
    ev = 0; eid = 0;
    for (int b = NB - 1; b >= 0; b--) begin
      if (hh >= mx[0][b] && hh < mx[0][b] + BS &&
          vv >= my[0][b] && vv < my[0][b] + BS) begin
        ev = 1; eid = b;
      end
    end
    @(negedge clk); h = 10'(hh); v = 10'(vv);
    @(posedge clk); #1;
    chk($sformatf("video (%0d,%0d)", hh, vv), int'(vid[0]), ev);
    chk($sformatf("ball_id (%0d,%0d)", hh, vv), int'(bid[0]), eid);
  endtask

  initial begin
    int x, y, hh, vv, b;
    vecs[0] = '{33, 33, 1, 0};
    vecs[1] = '{40, 33, 0, 0};
    vecs[2] = '{39, 39, 1, 0};
    vecs[3] = '{31, 32, 0, 0};
    vecs[4] = '{96, 80, 1, 1};
    vecs[5] = '{103, 87, 1, 1};
    vecs[6] = '{104, 80, 0, 0};
    vecs[7] = '{96, 88, 0, 0};

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("reset video", int'(vid[0]), 0);
    chk("reset id", int'(bid[0]), 0);
    chk("reset bounce", int'(bnc[0]), 0);
    chk("reset done", int'(fd[0]), 0);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 3; c++) check_pos(c);

    foreach (vecs[i]) begin
      @(negedge clk); h = 10'(vecs[i].hh); v = 10'(vecs[i].vv);
      @(posedge clk); #1;
      chk($sformatf("vec%0d video", i), int'(vid[0]), vecs[i].vid);
      chk($sformatf("vec%0d id", i), int'(bid[0]), vecs[i].id);
    end

    for (int t = 1; t <= 301; t++) begin
      do_tick();
      if (t == 1) begin
        get_pos(0, 0, x, y);
        chk("t1 b0 x", x, 34); chk("t1 b0 y", y, 34);
        get_pos(0, 1, x, y);
        chk("t1 b1 x", x, 94); chk("t1 b1 y", y, 82);
        chk("t1 done early", int'(done_s[0][1]), 0);
        chk("t1 done", int'(done_s[0][2]), 1);
      end
      if (t == 2 || t == 3) begin
        get_pos(2, 0, x, y);
        chk($sformatf("div t%0d x", t), x, (t == 2) ? 32 : 34);
      end
      if (t == 139 || t == 140) begin
        get_pos(1, 0, x, y);
        chk($sformatf("net t%0d x", t), x, (t == 139) ? 308 : 306);
        if (t == 139) chk("net bounce", int'(bnc_s[1][1]), 1);
      end
      if (t == 220 || t == 221) begin
        get_pos(0, 0, x, y);
        chk($sformatf("wall t%0d y", t), y, (t == 220) ? 472 : 470);
        if (t == 220) chk("bottom bounce", int'(bnc_s[0][1]), 1);
      end
      if (t == 300 || t == 301) begin
        get_pos(0, 0, x, y);
        chk($sformatf("wall t%0d x", t), x, (t == 300) ? 632 : 630);
        if (t == 300) chk("right bounce", int'(bnc_s[0][1]), 1);
      end
    end

    pause = 1'b1;
    repeat (5) do_tick();
    pause = 1'b0;

    for (int r = 0; r < 40; r++) begin
      pause = ($urandom_range(0, 3) == 0);
      do_tick();
      pause = 1'b0;
      for (int p = 0; p < 5; p++) begin
        b = int'($urandom_range(0, NB - 1));
        hh = mx[0][b] + int'($urandom_range(0, BS + 3)) - 2;
        vv = my[0][b] + int'($urandom_range(0, BS + 3)) - 2;
        if (hh < 0) hh = 0;
        if (vv < 0) vv = 0;
        if (hh == 0 && vv == VA) hh = 1;
        probe(hh, vv);
      end
    end

    @(negedge clk); h = 10'd0; v = 10'(VA);
    @(posedge clk); #1; h = 10'd33; v = 10'd33;
    @(posedge clk); #1;
    chk("mid-sweep ball0 moved", int'(dut0.x_q[0] != 10'(mx[0][0])), 1);
    rst = 1'b1;
    #1;
    model_reset();
    for (int c = 0; c < 3; c++) check_pos(c);
    chk("rst video", int'(vid[0]), 0);
    chk("rst bounce", int'(bnc[0]), 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst hold video", int'(vid[0]), 0);
    chk("rst hold id", int'(bid[0]), 0);
    chk("rst hold done", int'(fd[0]), 0);
    chk("rst hold bounce", int'(bnc[0]), 0);
    @(negedge clk); rst = 1'b0;
    do_tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
